// File: rtl/pci_cfg_seq_pkg.sv
// Shared types, widths and helpers for the configuration-access sequencer.
package pci_cfg_seq_pkg;

  localparam int CFG_OFFSET_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR_ISSUE,
    ST_RESP
  } cfg_seq_state_t;

  // Byte-lane merge: lanes with be set come from new_val, the rest keep old_val.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pci_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last grant; on a
// tie the other requester wins. The pointer powers up pointing at 1 so that
// requester 0 wins the first tie.
module pci_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       upd_idx_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  logic ptr_q;

  // Last-grant pointer, written once per completed transaction.
  always_ff @(posedge clk) begin
    if (rst)           ptr_q <= 1'b1;
    else if (update_i) ptr_q <= upd_idx_i;
  end

  // Winner selection: single requester wins outright, a tie goes to !ptr.
  always_comb begin
    gnt_o     = 2'b00;
    gnt_idx_o = 1'b0;
    if (req_i == 2'b11)  gnt_idx_o = ~ptr_q;
    else if (req_i[1])   gnt_idx_o = 1'b1;
    if (req_i != 2'b00)  gnt_o = gnt_idx_o ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/pci_cfg_seq.sv
// Configuration-access sequencer: arbitrates the bus target and MSI engine,
// waits out register-file read latency and turns partial writes into
// read-modify-write sequences.
module pci_cfg_seq
  import pci_cfg_seq_pkg::*;
#(
  parameter int CFG_RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_write,
  input  logic [CFG_OFFSET_W-1:0] req0_offset,
  input  logic [3:0]              req0_be,
  input  logic [31:0]             req0_wdata,
  output logic                    rsp0_valid,
  output logic [31:0]             rsp0_rdata,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_write,
  input  logic [CFG_OFFSET_W-1:0] req1_offset,
  input  logic [3:0]              req1_be,
  input  logic [31:0]             req1_wdata,
  output logic                    rsp1_valid,
  output logic [31:0]             rsp1_rdata,
  output logic                    cfg_enable,
  output logic                    cfg_iswrite,
  output logic [CFG_OFFSET_W-1:0] cfg_offset,
  output logic [31:0]             cfg_write_val,
  input  logic [31:0]             cfg_read_val
);

  localparam logic [1:0] LAT_M1 = 2'(CFG_RD_LAT - 1);

  cfg_seq_state_t          state_q, state_d;
  logic                    write_q, write_d;
  logic [CFG_OFFSET_W-1:0] offset_q, offset_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    idx_q, idx_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [31:0]             wval_q, wval_d;

  logic [1:0] gnt;
  logic       gnt_idx;
  logic       arb_update;
  logic       sel_write;
  logic [3:0] sel_be;
  logic       rsp_fire;

  pci_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({req1_valid, req0_valid}),
    .update_i  (arb_update),
    .upd_idx_i (idx_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign sel_write = gnt_idx ? req1_write : req0_write;
  assign sel_be    = gnt_idx ? req1_be    : req0_be;

  // Next-state and latch logic for the single in-flight request.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    offset_d   = offset_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    wval_d     = wval_q;
    arb_update = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          write_d  = sel_write;
          offset_d = gnt_idx ? req1_offset : req0_offset;
          be_d     = sel_be;
          wdata_d  = gnt_idx ? req1_wdata : req0_wdata;
          wval_d   = gnt_idx ? req1_wdata : req0_wdata;
          idx_d    = gnt_idx;
          if (!sel_write)            state_d = ST_RD_ISSUE;
          else if (sel_be == 4'hF)   state_d = ST_WR_ISSUE;
          else if (sel_be == 4'h0)   state_d = ST_RESP;
          else                       state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = cfg_read_val;
          if (write_q) begin
            wval_d  = be_merge(cfg_read_val, wdata_q, be_q);
            state_d = ST_WR_ISSUE;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_WR_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        arb_update = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched request registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      offset_q <= '0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      idx_q    <= 1'b0;
      cnt_q    <= 2'd0;
      rdata_q  <= 32'h0;
      wval_q   <= 32'h0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      offset_q <= offset_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      wval_q   <= wval_d;
    end
  end

  // Output decode; reset suppresses grants, strobes and responses at once.
  always_comb begin
    rsp_fire      = (state_q == ST_RESP) && !rst;
    req0_ready    = (state_q == ST_IDLE) && !rst && gnt[0];
    req1_ready    = (state_q == ST_IDLE) && !rst && gnt[1];
    cfg_enable    = !rst && ((state_q == ST_RD_ISSUE) || (state_q == ST_WR_ISSUE));
    cfg_iswrite   = !rst && (state_q == ST_WR_ISSUE);
    cfg_offset    = offset_q;
    cfg_write_val = wval_q;
    rsp0_valid    = rsp_fire && !idx_q;
    rsp1_valid    = rsp_fire && idx_q;
    rsp0_rdata    = (rsp_fire && !idx_q && !write_q) ? rdata_q : 32'h0;
    rsp1_rdata    = (rsp_fire && idx_q && !write_q) ? rdata_q : 32'h0;
  end

endmodule
